// File: rtl/cnn_pkg.sv
// Shared types and per-layer configuration tables for the CNN layer sequencer.
package cnn_pkg;

  localparam int unsigned MAX_LAYERS = 8;

  typedef enum logic [1:0] {CONV, POOL, FC} layer_type_t;

  typedef enum logic [2:0] {IDLE, ARM, RUN, FLUSH, DONE} state_t;

  localparam logic [7:0] STATUS_TIMEOUT = 8'hFC;
  localparam logic [7:0] STATUS_ABORT   = 8'hFD;
  localparam logic [7:0] STATUS_BAD_IDX = 8'hFE;

  // Entries past the fifth only matter for builds with more than five layers.
  localparam layer_type_t LAYER_TYPE [MAX_LAYERS] =
    '{CONV, POOL, CONV, POOL, FC, CONV, CONV, CONV};
  localparam logic [1:0] MAC_LAYER [MAX_LAYERS] =
    '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0};

  function automatic logic layer_is_pool(input logic [2:0] idx);
    return LAYER_TYPE[idx] == POOL;
  endfunction

  function automatic logic [1:0] layer_mac_sel(input logic [2:0] idx);
    return MAC_LAYER[idx];
  endfunction

endpackage

// File: rtl/cnn_seq_timer.sv
// Per-layer RUN watchdog: flags the cycle on which a layer has spent
// TIMEOUT_CYCLES cycles in RUN. Only instantiated with CNN_SEQ_TIMEOUT_EN.
module cnn_seq_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count holds at LIMIT so it can never wrap while RUN is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = enable && (count == LIMIT);

endmodule

// File: rtl/cnn_layer_seq.sv
// Sequences CNN layers through ARM/RUN/FLUSH, driving per-layer enables and
// datapath mode controls. Optional RUN watchdog via CNN_SEQ_TIMEOUT_EN.
module cnn_layer_seq
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  input  logic [7:0]            cmd,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [NUM_LAYERS-1:0] mem_reset,
  output logic                  mac_enable,
  output logic                  rmac,
  output logic                  pooling_layer,
  output logic                  img_load,
  output logic [1:0]            mac_layer,
  output logic                  busy,
  output logic                  irq,
  output logic [7:0]            status
);

  localparam int unsigned IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  if (NUM_LAYERS < 2 || NUM_LAYERS > MAX_LAYERS || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("cnn_layer_seq: unsupported NUM_LAYERS or TIMEOUT_CYCLES");
  end

  state_t           state, nxt_state;
  logic [IDX_W-1:0] cur, nxt_cur;
  logic             auto_mode, nxt_auto;
  logic [7:0]       nxt_status;
  logic             nxt_irq;
  logic             abort_c;
  logic             timeout_c;
  logic [IDX_W-1:0] cmd_idx;
  logic             unused_cmd;

  assign abort_c    = cmd_valid && cmd[6];
  assign cmd_idx    = cmd[IDX_W-1:0];
  assign unused_cmd = ^cmd[5:IDX_W];

`ifdef CNN_SEQ_TIMEOUT_EN
  cnn_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state == ARM),
    .enable    (state == RUN),
    .expired_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state decode; abort outranks everything, including layer_done.
  always_comb begin
    nxt_state  = state;
    nxt_cur    = cur;
    nxt_auto   = auto_mode;
    nxt_status = status;
    nxt_irq    = 1'b0;
    if (abort_c) begin
      nxt_state  = IDLE;
      nxt_status = STATUS_ABORT;
      nxt_irq    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (32'(cmd_idx) < NUM_LAYERS) begin
              nxt_state = ARM;
              nxt_cur   = cmd_idx;
              nxt_auto  = cmd[7];
            end else begin
              nxt_status = STATUS_BAD_IDX;
              nxt_irq    = 1'b1;
            end
          end
        end
        ARM: nxt_state = RUN;
        RUN: begin
          if (timeout_c) begin
            nxt_state  = IDLE;
            nxt_status = STATUS_TIMEOUT;
            nxt_irq    = 1'b1;
          end else if (layer_done[cur]) begin
            nxt_state = FLUSH;
          end
        end
        FLUSH: begin
          if (auto_mode && (32'(cur) < NUM_LAYERS - 1)) begin
            nxt_state = ARM;
            nxt_cur   = cur + IDX_W'(1);
          end else begin
            nxt_state  = DONE;
            nxt_status = 8'(cur) + 8'd1;
            nxt_irq    = 1'b1;
          end
        end
        DONE:    nxt_state = IDLE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  logic [2:0]            nxt_idx;
  logic [NUM_LAYERS-1:0] nxt_onehot;
  logic [NUM_LAYERS-1:0] d_layer_en, d_mem_reset;
  logic                  d_mac_enable, d_rmac, d_pooling, d_img_load, d_busy;
  logic [1:0]            d_mac_layer;

  assign nxt_idx    = 3'(nxt_cur);
  assign nxt_onehot = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << nxt_cur;

  // Output decode for the state being entered, so every output is a flop.
  always_comb begin
    d_layer_en   = '0;
    d_mem_reset  = '1;
    d_mac_enable = 1'b0;
    d_rmac       = 1'b1;
    d_pooling    = 1'b0;
    d_img_load   = 1'b0;
    d_mac_layer  = 2'd0;
    d_busy       = 1'b1;
    unique case (nxt_state)
      IDLE: begin
        d_img_load = 1'b1;
        d_busy     = 1'b0;
      end
      ARM: begin
        d_layer_en  = nxt_onehot;
        d_mac_layer = layer_mac_sel(nxt_idx);
      end
      RUN: begin
        d_layer_en  = nxt_onehot;
        d_mem_reset = ~nxt_onehot;
        d_mac_layer = layer_mac_sel(nxt_idx);
        if (layer_is_pool(nxt_idx)) begin
          d_pooling = 1'b1;
        end else begin
          d_mac_enable = 1'b1;
          d_rmac       = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cur           <= '0;
      auto_mode     <= 1'b0;
      status        <= 8'h00;
      irq           <= 1'b0;
      busy          <= 1'b0;
      layer_en      <= '0;
      mem_reset     <= '1;
      img_load      <= 1'b1;
      rmac          <= 1'b1;
      mac_enable    <= 1'b0;
      pooling_layer <= 1'b0;
      mac_layer     <= 2'd0;
    end else begin
      state         <= nxt_state;
      cur           <= nxt_cur;
      auto_mode     <= nxt_auto;
      status        <= nxt_status;
      irq           <= nxt_irq;
      busy          <= d_busy;
      layer_en      <= d_layer_en;
      mem_reset     <= d_mem_reset;
      img_load      <= d_img_load;
      rmac          <= d_rmac;
      mac_enable    <= d_mac_enable;
      pooling_layer <= d_pooling;
      mac_layer     <= d_mac_layer;
    end
  end

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Self-checking bench for cnn_layer_seq: command table with a status
// scoreboard, plus directed latency, abort, ignore/reset and timeout sequences.
module tb_cnn_layer_seq;

  localparam int unsigned NL = 5;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic [7:0]    cmd;
  logic [NL-1:0] layer_done = '0;
  logic [NL-1:0] layer_en, mem_reset;
  logic          mac_enable, rmac, pooling_layer, img_load, busy, irq;
  logic [1:0]    mac_layer;
  logic [7:0]    status;

  cnn_layer_seq #(.NUM_LAYERS(NL), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd(cmd),
    .layer_done(layer_done), .layer_en(layer_en), .mem_reset(mem_reset),
    .mac_enable(mac_enable), .rmac(rmac), .pooling_layer(pooling_layer),
    .img_load(img_load), .mac_layer(mac_layer), .busy(busy), .irq(irq),
    .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    cmd;
    int            run_len;
    logic [7:0]    exp_status;
    logic [NL-1:0] exp_layers;
    int            exp_run;
  } vec_t;

  localparam logic [25:0] RST_VEC =
    {5'b00000, 5'b11111, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00};

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sb[$];

  int            run_len = 0;
  logic [NL-1:0] stall_mask = '0;
  logic [NL-1:0] extra_done = '0;
  logic [NL-1:0] layers_seen = '0;
  int            run_total = 0;
  int            run_cnt = 0;
  int            irq_cnt = 0;

  logic       exp_pool [NL] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] exp_ml   [NL] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] outs();
    return {layer_en, mem_reset, mac_enable, rmac, pooling_layer, img_load,
            mac_layer, busy, irq, status};
  endfunction

  // Monitor: tracks RUN activity, drives layer_done, checks irq against scoreboard.
  always @(negedge clk) begin : monitor
    logic [NL-1:0] auto_done;
    int            idx;
    auto_done = '0;
    if (reset_n) begin
      layers_seen = layers_seen | layer_en;
      if (mem_reset != 5'b11111) begin
        run_total++;
        run_cnt++;
        idx = 0;
        for (int k = 0; k < NL; k++) if (layer_en[k]) idx = k;
        check("run_cfg",
              {27'd0, $onehot(layer_en), mem_reset, mac_enable, rmac, pooling_layer, mac_layer},
              {27'd0, 1'b1, ~(5'b00001 << idx), !exp_pool[idx], exp_pool[idx],
               exp_pool[idx], exp_ml[idx]});
        if (run_len != 0 && run_cnt >= run_len && (layer_en & stall_mask) == '0)
          auto_done = layer_en;
      end else begin
        run_cnt = 0;
      end
      if (irq) begin
        irq_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL irq_unexpected: got status %0h want no irq (t=%0t)", status, $time);
        end else begin
          check("irq_status", status, sb.pop_front());
        end
      end
    end else begin
      run_cnt = 0;
    end
    layer_done = auto_done | extra_done;
  end

  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd       = c;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd       = 8'h00;
  endtask

  task automatic wait_irq(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (irq_cnt > 0) break;
      @(posedge clk); #1;
    end
    if (irq_cnt == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL irq_timeout: got no irq want irq within %0d cycles", budget);
    end
  endtask

  task automatic clear_track(input int rl, input logic [NL-1:0] stall);
    run_len     = rl;
    stall_mask  = stall;
    extra_done  = '0;
    layers_seen = '0;
    run_total   = 0;
    irq_cnt     = 0;
  endtask

  vec_t vecs [8];
  logic found;
  int   hold;

  initial begin : stim
    vecs[0] = '{8'h00, 10, 8'h01, 5'b00001, 10};
    vecs[1] = '{8'h80,  5, 8'h05, 5'b11111, 25};
    vecs[2] = '{8'h07,  5, 8'hFE, 5'b00000,  0};
    vecs[3] = '{8'h83,  3, 8'h05, 5'b11000,  6};
    vecs[4] = '{8'h04,  1, 8'h05, 5'b10000,  1};
    vecs[5] = '{8'h02,  2, 8'h03, 5'b00100,  2};
    vecs[6] = '{8'h05,  3, 8'hFE, 5'b00000,  0};
    vecs[7] = '{8'h84,  4, 8'h05, 5'b10000,  4};

    cmd_valid = 1'b0;
    cmd       = 8'h00;
    reset_n   = 1'b1;
    #3 reset_n = 1'b0;
    #1 check("reset_outs", 32'(outs()), 32'(RST_VEC));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", 32'(outs()), 32'(RST_VEC));

    for (int i = 0; i < 8; i++) begin
      clear_track(vecs[i].run_len, '0);
      sb.push_back(vecs[i].exp_status);
      send_cmd(vecs[i].cmd);
      wait_irq(400);
      repeat (3) @(posedge clk); #1;
      check($sformatf("v%0d_irq_count", i), irq_cnt, 1);
      check($sformatf("v%0d_layers", i), 32'(layers_seen), 32'(vecs[i].exp_layers));
      check($sformatf("v%0d_run_cycles", i), run_total, vecs[i].exp_run);
      check($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].exp_status));
      check($sformatf("v%0d_busy", i), 32'(busy), 0);
    end

    // Cycle-exact latency; layer_done already high at RUN entry.
    clear_track(0, '0);
    sb.push_back(8'h01);
    send_cmd(8'h00);
    check("arm_outs", {22'd0, layer_en, mem_reset}, {22'd0, 5'b00001, 5'b11111});
    check("arm_ctrl", {29'd0, busy, img_load, mac_enable}, {29'd0, 3'b100});
    extra_done = 5'b00001;
    @(posedge clk); #1;
    check("run_outs", {22'd0, layer_en, mem_reset}, {22'd0, 5'b00001, 5'b11110});
    check("run_ctrl", {29'd0, mac_enable, rmac, busy}, {29'd0, 3'b101});
    @(posedge clk); #1;
    extra_done = '0;
    check("flush_outs", {19'd0, layer_en, mem_reset, mac_enable, busy, irq},
          {19'd0, 5'b00000, 5'b11111, 3'b010});
    @(posedge clk); #1;
    check("done_outs", {23'd0, irq, status}, {23'd0, 1'b1, 8'h01});
    @(posedge clk); #1;
    check("idle_outs", {19'd0, busy, irq, img_load, rmac, layer_en, mem_reset},
          {19'd0, 4'b0011, 5'b00000, 5'b11111});
    check("latency_run_cycles", run_total, 1);

    // Abort in RUN of layer 2 together with layer_done[2].
    clear_track(2, 5'b00100);
    sb.push_back(8'hFD);
    send_cmd(8'h80);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (layer_en == 5'b00100 && mem_reset == 5'b11011) found = 1'b1;
    end
    check("reach_run_layer2", 32'(found), 1);
    extra_done = 5'b00100;
    cmd_valid  = 1'b1;
    cmd        = 8'h40;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd        = 8'h00;
    extra_done = '0;
    check("abort_outs", {18'd0, busy, layer_en, irq, status},
          {18'd0, 1'b0, 5'b00000, 1'b1, 8'hFD});
    repeat (6) @(posedge clk); #1;
    check("abort_layers", 32'(layers_seen), 32'(5'b00111));
    check("abort_irq_count", irq_cnt, 1);

    // Foreign layer_done and non-abort command ignored in RUN; reset mid-RUN.
`ifdef CNN_SEQ_TIMEOUT_EN
    hold = 3;
`else
    hold = 20;
`endif
    clear_track(0, '0);
    send_cmd(8'h01);
    @(posedge clk); #1;
    extra_done = 5'b01000;
    repeat (hold) @(posedge clk); #1;
    check("ignore_foreign_done", {20'd0, layer_en, mem_reset, pooling_layer, busy},
          {20'd0, 5'b00010, 5'b11101, 2'b11});
    send_cmd(8'h00);
    @(posedge clk); #1;
    check("ignore_cmd_in_run", {21'd0, layer_en, mem_reset, busy},
          {21'd0, 5'b00010, 5'b11101, 1'b1});
    extra_done = '0;
    reset_n    = 1'b0;
    #1 check("reset_mid_run", 32'(outs()), 32'(RST_VEC));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_no_irq", irq_cnt, 0);
    check("reset_idle", 32'(outs()), 32'(RST_VEC));

`ifdef CNN_SEQ_TIMEOUT_EN
    clear_track(0, '0);
    sb.push_back(8'hFC);
    send_cmd(8'h00);
    wait_irq(200);
    repeat (2) @(posedge clk); #1;
    check("timeout_run_cycles", run_total, 16);
    check("timeout_irq_count", irq_cnt, 1);
    check("timeout_busy", 32'(busy), 0);
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test want finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
